// File: rtl/count_event_logger.sv
// Monitors a small up/down counter and queues timestamped records of wraps,
// non-unit jumps and direction changes in a FIFO drained over valid/ready.
module count_event_logger #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [WIDTH-1:0]        cnt_in,
  input  logic                    sel,
  input  logic                    evt_ready,
  input  logic                    clr_ovf,
  output logic                    evt_valid,
  output logic [2:0]              evt_code,
  output logic [WIDTH-1:0]        evt_count,
  output logic [TS_WIDTH-1:0]     evt_time,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {PRIME, RUN} state_e;
  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_WRAP_UP = 3'd1,
    EV_WRAP_DN = 3'd2,
    EV_JUMP    = 3'd3,
    EV_SEL_CHG = 3'd4
  } evt_e;

  state_e              state_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH-1:0]    prev_cnt_q;
  logic                prev_sel_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;

  logic [2:0]          code_mem [DEPTH];
  logic [WIDTH-1:0]    cnt_mem  [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

  logic [WIDTH-1:0]    cnt_inc, cnt_dec;
  evt_e                ev_code;
  logic                ev_hit, pop, push, drop;

  always_comb begin
    cnt_inc = prev_cnt_q + 1'b1;
    cnt_dec = prev_cnt_q - 1'b1;
    ev_code = EV_NONE;
    // Priority order: jump, wrap up, wrap down, direction change.
    if (state_q == RUN) begin
      if (cnt_in != prev_cnt_q && cnt_in != cnt_inc && cnt_in != cnt_dec)
        ev_code = EV_JUMP;
      else if (prev_cnt_q == '1 && cnt_in == '0)
        ev_code = EV_WRAP_UP;
      else if (prev_cnt_q == '0 && cnt_in == '1)
        ev_code = EV_WRAP_DN;
      else if (sel != prev_sel_q)
        ev_code = EV_SEL_CHG;
    end
    ev_hit = (ev_code != EV_NONE);
    pop    = (level_q != '0) && evt_ready;
    push   = ev_hit && ((level_q != FULL) || pop);
    drop   = ev_hit && (level_q == FULL) && !pop;

    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;

    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= PRIME;
      ts_q       <= '0;
      prev_cnt_q <= '0;
      prev_sel_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= RUN;
      ts_q       <= ts_q + 1'b1;
      prev_cnt_q <= cnt_in;
      prev_sel_q <= sel;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked by the level while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q] <= ev_code;
      cnt_mem[wr_ptr_q]  <= cnt_in;
      ts_mem[wr_ptr_q]   <= ts_q;
    end
  end

  assign evt_valid  = (level_q != '0);
  assign evt_code   = evt_valid ? code_mem[rd_ptr_q] : '0;
  assign evt_count  = evt_valid ? cnt_mem[rd_ptr_q]  : '0;
  assign evt_time   = evt_valid ? ts_mem[rd_ptr_q]   : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule
